lvds_rx_deser: RTL and testbench
================================

LVDS_RX_DESER -- requirements
Module: lvds_rx_deser

Interface
REQ-001 Parameter LOCK_CNT, default 4, consecutive boundary-aligned clock-lane matches required to declare lock.
REQ-002 Parameter UNLOCK_CNT, default 2, consecutive boundary mismatches that drop lock.
REQ-003 iOSC  in  1  single clock, 7x pixel rate, one serial bit per lane per cycle.
REQ-004 iRESET  in  1  asynchronous, active-low reset.
REQ-005 iRX_CLK  in  1  sampled LVDS clock lane (post-IBUFDS, already in iOSC domain).
REQ-006 iRX_DATA  in  4  sampled data lanes 0..3.
REQ-007 oPIX_VALID  out  1  one-cycle pulse per decoded pixel word.
REQ-008 oR / oG / oB  out  8 each  decoded colour.
REQ-009 oDE / oHS / oVS  out  1 each  decoded control bits.
REQ-010 oLOCK  out  1  word alignment locked.
REQ-011 oERR_CNT  out  8  saturating count of clock-lane mismatches while locked.

Function
REQ-012 Each lane shall shift into a 7-bit register every cycle; bit 6 is the oldest (first-received) bit.
REQ-013 A 3-bit slot counter shall count 0..6 and wrap; a word boundary is slot==6.
REQ-014 FSM states SEARCH, VERIFY, LOCKED; reset state SEARCH.
REQ-015 SEARCH: on any cycle where clock-lane word == 7'b1100011, the slot counter shall be forced to 6 in that cycle; go VERIFY with match count 1.
REQ-016 VERIFY: at each boundary, match increments count, mismatch returns to SEARCH; count reaching LOCK_CNT enters LOCKED.
REQ-017 LOCKED: oLOCK=1; at each boundary a mismatch increments oERR_CNT (saturating at 255) and the miss count; a match clears the miss count; miss count reaching UNLOCK_CNT returns to SEARCH, oLOCK=0 the next cycle.
REQ-018 Simultaneous last LOCK_CNT match and any other event: the match wins; entry to LOCKED is never delayed.
REQ-019 Default (VESA) mapping, word w[6:0] per lane: lane0 {G0,R5,R4,R3,R2,R1,R0}; lane1 {B1,B0,G5,G4,G3,G2,G1}; lane2 {DE,VS,HS,B5,B4,B3,B2}; lane3 {rsvd,B7,B6,G7,G6,R7,R6}.
REQ-020 Outputs shall be registered: colour/control and a oPIX_VALID pulse appear the cycle after a boundary in LOCKED; total latency from last bit of a word on the pins to oPIX_VALID = 2 cycles.
REQ-021 Outside LOCKED, oPIX_VALID=0 and colour/control outputs hold their last values.
REQ-022 The word at which LOCKED is entered shall itself be emitted (first valid pulse follows the LOCK_CNT-th match).
REQ-023 Reserved bit shall be ignored.

Reset
REQ-024 iRESET low shall asynchronously force: state SEARCH, slot 0, shift registers 0, all counters 0, oPIX_VALID/oLOCK/oDE/oHS/oVS 0, oR/oG/oB 0, oERR_CNT 0.
REQ-025 Reset asserted mid-word or while LOCKED shall discard partial words; no pulse on oPIX_VALID after release until relock.
REQ-026 Release is synchronized internally to iOSC (two-flop deassert).

Configuration
REQ-027 Macro LVDS_RX_JEIDA_EN: when defined, mapping shall be JEIDA: lane0 {G2,R7,R6,R5,R4,R3,R2}; lane1 {B3,B2,G7,G6,G5,G4,G3}; lane2 {DE,VS,HS,B7,B6,B5,B4}; lane3 {rsvd,B1,B0,G1,G0,R1,R0}; when undefined, REQ-019 applies. Alignment logic is identical either way.

Structure
REQ-028 Package lvds_rx_pkg shall hold: FSM state type, CLK_PATTERN=7'b1100011, WORD_W=7, LANE_N=4.
REQ-029 Sub-module lvds_rx_align shall contain the clock-lane shift register, slot counter, FSM, miss/match counters and oERR_CNT; it exports boundary strobe and lock; the top performs data shifting and bit mapping.

Verification
REQ-030 Reset release, clock lane repeating 1100011, lanes carrying R=8'hA5,G=8'h3C,B=8'hF0,DE=1 -> oLOCK rises after 4 boundaries, oPIX_VALID every 7 cycles, outputs match exactly.
REQ-031 Clock lane started at phase offset 3 -> lock achieved with same decoded values, no spurious pulse before lock.
REQ-032 While locked, corrupt one clock word -> oERR_CNT=1, oLOCK stays 1; corrupt two consecutive -> oLOCK=0, oPIX_VALID stops, relock after 4 good words.
REQ-033 Inject 300 isolated single-word errors (good word between each) -> oERR_CNT saturates at 255, lock retained.
REQ-034 Assert iRESET mid-word while locked -> all outputs 0 immediately; after release oLOCK=0 until 4 matches.
REQ-035 Build with LVDS_RX_JEIDA_EN, drive JEIDA-encoded R=8'h81,G=8'h42,B=8'h24,HS=1 -> decoded exactly; same stream without macro decodes per VESA mapping.

Source files
------------

// File: rtl/lvds_rx_pkg.sv
// Shared types and constants for the 7:1 LVDS receive deserializer.
package lvds_rx_pkg;

    localparam int WORD_W = 7;
    localparam int LANE_N = 4;

    localparam logic [WORD_W-1:0] CLK_PATTERN = 7'b1100011;
    localparam logic [2:0]        SLOT_LAST   = 3'd6;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/lvds_rx_align.sv
// Clock-lane word alignment: pattern tracking, slot counter, lock FSM and
// saturating error count for mismatches seen while locked.
module lvds_rx_align
    import lvds_rx_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_clk,
    output logic       o_bnd_stb,
    output logic       o_lock,
    output logic [7:0] o_err_cnt
);

    localparam logic [7:0] LOCK_N   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_CNT);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [WORD_W-1:0] r_clk_sr_p0;
    logic [2:0]        r_slot;
    logic [7:0]        r_match_cnt;
    logic [7:0]        r_miss_cnt;
    logic [7:0]        r_err_cnt;
    logic              w_match;
    logic              w_force;
    logic              w_bnd;
    logic              w_lock_hit;
    logic              w_unlock_hit;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // stage p0: clock-lane shift register, bit 6 is the first-received bit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_sr_p0 <= '0;
        end else begin
            r_clk_sr_p0 <= {r_clk_sr_p0[WORD_W-2:0], i_rx_clk};
        end
    end

    assign w_match      = (r_clk_sr_p0 == CLK_PATTERN);
    // while searching, a pattern hit is treated as slot 6 in the same cycle
    assign w_force      = (r_state == ST_SEARCH) && w_match;
    assign w_bnd        = w_force || (r_slot == SLOT_LAST);
    assign w_lock_hit   = ((r_match_cnt + 8'd1) >= LOCK_N);
    assign w_unlock_hit = ((r_miss_cnt + 8'd1) >= UNLOCK_N);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SEARCH: begin
                if (w_force) begin
                    w_state_nxt = w_lock_hit ? ST_LOCKED : ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (w_bnd) begin
                    if (!w_match) begin
                        w_state_nxt = ST_SEARCH;
                    end else if (w_lock_hit) begin
                        w_state_nxt = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_bnd && !w_match && w_unlock_hit) begin
                    w_state_nxt = ST_SEARCH;
                end
            end
            default: w_state_nxt = ST_SEARCH;
        endcase
    end

    // the word that completes lock is emitted along with every locked word
    always_comb begin
        o_lock    = (r_state == ST_LOCKED);
        o_bnd_stb = w_bnd && ((r_state == ST_LOCKED) || (w_state_nxt == ST_LOCKED));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot      <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_slot <= w_bnd ? 3'd0 : r_slot + 3'd1;
            case (r_state)
                ST_SEARCH: begin
                    r_match_cnt <= w_force ? 8'd1 : 8'd0;
                    r_miss_cnt  <= '0;
                end
                ST_VERIFY: begin
                    if (w_bnd) begin
                        r_match_cnt <= w_match ? r_match_cnt + 8'd1 : 8'd0;
                    end
                end
                ST_LOCKED: begin
                    r_match_cnt <= '0;
                    if (w_bnd) begin
                        if (w_match) begin
                            r_miss_cnt <= '0;
                        end else begin
                            r_miss_cnt <= w_unlock_hit ? 8'd0 : r_miss_cnt + 8'd1;
                            r_err_cnt  <= sat_inc(r_err_cnt);
                        end
                    end
                end
                default: begin
                    r_match_cnt <= '0;
                    r_miss_cnt  <= '0;
                end
            endcase
        end
    end

    assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/lvds_rx_deser.sv
// 4-lane 7:1 LVDS receive deserializer with clock-lane word alignment.
// Define LVDS_RX_JEIDA_EN for JEIDA bit mapping; VESA mapping otherwise.
module lvds_rx_deser
    import lvds_rx_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2
) (
    input  logic              iOSC,
    input  logic              iRESET,
    input  logic              iRX_CLK,
    input  logic [LANE_N-1:0] iRX_DATA,
    output logic              oPIX_VALID,
    output logic [7:0]        oR,
    output logic [7:0]        oG,
    output logic [7:0]        oB,
    output logic              oDE,
    output logic              oHS,
    output logic              oVS,
    output logic              oLOCK,
    output logic [7:0]        oERR_CNT
);

    logic [1:0]                    r_rst_sync;
    logic                          w_rst_n;
    logic [LANE_N-1:0][WORD_W-1:0] r_lane_sr_p0;
    logic                          w_bnd_stb;
    logic [7:0]                    w_r;
    logic [7:0]                    w_g;
    logic [7:0]                    w_b;
    logic                          w_de;
    logic                          w_hs;
    logic                          w_vs;
    logic                          w_unused_rsvd;
    logic                          r_vld_p1;
    logic [7:0]                    r_r_p1;
    logic [7:0]                    r_g_p1;
    logic [7:0]                    r_b_p1;
    logic                          r_de_p1;
    logic                          r_hs_p1;
    logic                          r_vs_p1;

    // assert immediately, release after two iOSC edges
    always_ff @(posedge iOSC or negedge iRESET) begin
        if (!iRESET) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    lvds_rx_align #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_align (
        .i_clk     (iOSC),
        .i_rst_n   (w_rst_n),
        .i_rx_clk  (iRX_CLK),
        .o_bnd_stb (w_bnd_stb),
        .o_lock    (oLOCK),
        .o_err_cnt (oERR_CNT)
    );

    // stage p0: data-lane shift registers, aligned with the clock-lane register
    always_ff @(posedge iOSC or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_lane_sr_p0 <= '0;
        end else begin
            for (int i = 0; i < LANE_N; i++) begin
                r_lane_sr_p0[i] <= {r_lane_sr_p0[i][WORD_W-2:0], iRX_DATA[i]};
            end
        end
    end

    assign w_de          = r_lane_sr_p0[2][6];
    assign w_vs          = r_lane_sr_p0[2][5];
    assign w_hs          = r_lane_sr_p0[2][4];
    assign w_unused_rsvd = r_lane_sr_p0[3][6];

`ifdef LVDS_RX_JEIDA_EN
    assign w_r = {r_lane_sr_p0[0][5:0], r_lane_sr_p0[3][1:0]};
    assign w_g = {r_lane_sr_p0[1][4:0], r_lane_sr_p0[0][6], r_lane_sr_p0[3][3:2]};
    assign w_b = {r_lane_sr_p0[2][3:0], r_lane_sr_p0[1][6:5], r_lane_sr_p0[3][5:4]};
`else
    assign w_r = {r_lane_sr_p0[3][1:0], r_lane_sr_p0[0][5:0]};
    assign w_g = {r_lane_sr_p0[3][3:2], r_lane_sr_p0[1][4:0], r_lane_sr_p0[0][6]};
    assign w_b = {r_lane_sr_p0[3][5:4], r_lane_sr_p0[2][3:0], r_lane_sr_p0[1][6:5]};
`endif

    // stage p1: registered pixel outputs, held between emitted words
    always_ff @(posedge iOSC or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_vld_p1 <= 1'b0;
            r_r_p1   <= '0;
            r_g_p1   <= '0;
            r_b_p1   <= '0;
            r_de_p1  <= 1'b0;
            r_hs_p1  <= 1'b0;
            r_vs_p1  <= 1'b0;
        end else begin
            r_vld_p1 <= w_bnd_stb;
            if (w_bnd_stb) begin
                r_r_p1  <= w_r;
                r_g_p1  <= w_g;
                r_b_p1  <= w_b;
                r_de_p1 <= w_de;
                r_hs_p1 <= w_hs;
                r_vs_p1 <= w_vs;
            end
        end
    end

    assign oPIX_VALID = r_vld_p1;
    assign oR         = r_r_p1;
    assign oG         = r_g_p1;
    assign oB         = r_b_p1;
    assign oDE        = r_de_p1;
    assign oHS        = r_hs_p1;
    assign oVS        = r_vs_p1;

endmodule

// File: tb/tb_lvds_rx_deser.sv
// Directed bench for lvds_rx_deser: scoreboard of expected pixel words.
module tb_lvds_rx_deser;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       de;
        logic       hs;
        logic       vs;
    } pix_t;

    localparam logic [6:0] PAT = 7'b1100011;

    logic       iOSC     = 1'b0;
    logic       iRESET   = 1'b1;
    logic       iRX_CLK  = 1'b0;
    logic [3:0] iRX_DATA = 4'h0;
    logic       oPIX_VALID;
    logic [7:0] oR;
    logic [7:0] oG;
    logic [7:0] oB;
    logic       oDE;
    logic       oHS;
    logic       oVS;
    logic       oLOCK;
    logic [7:0] oERR_CNT;

    int   checks   = 0;
    int   failures = 0;
    pix_t exp_q[$];
    logic prev_vld = 1'b0;

    always #5 iOSC = ~iOSC;

    lvds_rx_deser dut (
        .iOSC       (iOSC),
        .iRESET     (iRESET),
        .iRX_CLK    (iRX_CLK),
        .iRX_DATA   (iRX_DATA),
        .oPIX_VALID (oPIX_VALID),
        .oR         (oR),
        .oG         (oG),
        .oB         (oB),
        .oDE        (oDE),
        .oHS        (oHS),
        .oVS        (oVS),
        .oLOCK      (oLOCK),
        .oERR_CNT   (oERR_CNT)
    );

    function automatic logic [27:0] enc(input pix_t p, input logic rsvd);
        logic [6:0] l0, l1, l2, l3;
`ifdef LVDS_RX_JEIDA_EN
        l0 = {p.g[2], p.r[7:2]};
        l1 = {p.b[3:2], p.g[7:3]};
        l2 = {p.de, p.vs, p.hs, p.b[7:4]};
        l3 = {rsvd, p.b[1:0], p.g[1:0], p.r[1:0]};
`else
        l0 = {p.g[0], p.r[5:0]};
        l1 = {p.b[1:0], p.g[5:1]};
        l2 = {p.de, p.vs, p.hs, p.b[5:2]};
        l3 = {rsvd, p.b[7:6], p.g[7:6], p.r[7:6]};
`endif
        return {l3, l2, l1, l0};
    endfunction

    function automatic pix_t rand_pix();
        pix_t p;
        p.r  = 8'($urandom);
        p.g  = 8'($urandom);
        p.b  = 8'($urandom);
        p.de = 1'($urandom_range(0, 1));
        p.hs = 1'($urandom_range(0, 1));
        p.vs = 1'($urandom_range(0, 1));
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [6:0] ck, input logic [27:0] lanes, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            @(posedge iOSC);
            #1;
            iRX_CLK  = ck[k];
            iRX_DATA = {lanes[21+k], lanes[14+k], lanes[7+k], lanes[k]};
        end
    endtask

    task automatic send_raw(input logic [6:0] ck, input logic [27:0] lanes,
                            input logic emit, input pix_t p);
        send_bits(ck, lanes, 7);
        if (emit) exp_q.push_back(p);
    endtask

    task automatic send_word(input logic [6:0] ck, input pix_t p, input logic rsvd,
                             input logic emit);
        send_raw(ck, enc(p, rsvd), emit, p);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge iOSC);
            #1;
            iRX_CLK  = 1'b0;
            iRX_DATA = 4'h0;
        end
    endtask

    // every pulse must match the oldest pending word and never repeat back-to-back
    always @(negedge iOSC) begin
        pix_t p;
        if (oPIX_VALID) begin
            checks++;
            assert (exp_q.size() > 0 && !prev_vld) else begin
                failures++;
                $error("FAIL pix_pulse observed=pulse(pending %0d prev %0b) expected=no pulse",
                       exp_q.size(), prev_vld);
            end
            if (exp_q.size() > 0) begin
                p = exp_q.pop_front();
                check("pix_data", {oR, oG, oB, oDE, oHS, oVS}, p);
            end
        end
        prev_vld = oPIX_VALID;
    end

    initial begin
        pix_t pa, pb, ph, pj;
        pa = '{r: 8'hA5, g: 8'h3C, b: 8'hF0, de: 1'b1, hs: 1'b0, vs: 1'b0};
        ph = '{r: 8'h11, g: 8'h22, b: 8'h33, de: 1'b1, hs: 1'b1, vs: 1'b0};

        iRESET = 1'b0;
        idle(3);
        check("rst_pix", {oPIX_VALID, oR, oG, oB, oDE, oHS, oVS}, 0);
        check("rst_ctl", {oLOCK, oERR_CNT}, 0);
        iRESET = 1'b1;
        idle(4);

        for (int w = 0; w < 3; w++) send_word(PAT, pa, 1'b0, 1'b0);
        send_word(PAT, pa, 1'b0, 1'b1);
        check("lock_before", oLOCK, 0);
        send_word(PAT, pa, 1'b1, 1'b1);
        check("lock_after", oLOCK, 1);
        for (int w = 0; w < 4; w++) send_word(PAT, rand_pix(), w[0], 1'b1);
        check("q_depth", exp_q.size(), 1);

        pb = rand_pix();
        send_word(7'b1110011, pb, 1'b0, 1'b1);
        send_word(PAT, pa, 1'b0, 1'b1);
        check("err_single", oERR_CNT, 1);
        check("lock_single", oLOCK, 1);

        send_word(7'b0000000, ph, 1'b0, 1'b1);
        send_word(7'b0000000, ph, 1'b0, 1'b1);
        send_word(PAT, pa, 1'b0, 1'b0);
        check("unlock_double", oLOCK, 0);
        check("err_double", oERR_CNT, 3);
        send_word(PAT, pa, 1'b0, 1'b0);
        send_word(PAT, pa, 1'b0, 1'b0);
        check("hold_pix", {oR, oG, oB, oDE, oHS, oVS}, ph);
        pb = rand_pix();
        send_word(PAT, pb, 1'b0, 1'b1);
        check("relock_before", oLOCK, 0);
        send_word(PAT, pa, 1'b0, 1'b1);
        check("relock_after", oLOCK, 1);

        for (int k = 0; k < 300; k++) begin
            send_word(7'b1111111, rand_pix(), 1'b0, 1'b1);
            send_word(PAT, rand_pix(), 1'b1, 1'b1);
            if (k == 99) check("err_mid", oERR_CNT, 103);
        end
        send_word(PAT, pa, 1'b0, 1'b1);
        check("err_sat", oERR_CNT, 255);
        check("lock_sat", oLOCK, 1);

        send_bits(PAT, enc(pa, 1'b0), 3);
        check("q_empty_rst", exp_q.size(), 0);
        iRESET = 1'b0;
        #1;
        check("rst_mid_pix", {oPIX_VALID, oR, oG, oB, oDE, oHS, oVS}, 0);
        check("rst_mid_ctl", {oLOCK, oERR_CNT}, 0);
        idle(3);
        iRESET = 1'b1;
        idle(4);
        check("rst_rel_lock", oLOCK, 0);

        send_bits(PAT, enc(rand_pix(), 1'b1), 3);
        for (int w = 0; w < 3; w++) send_word(PAT, pa, 1'b0, 1'b0);
        send_word(PAT, pa, 1'b0, 1'b1);
        check("lock_before_ofs", oLOCK, 0);
        send_word(PAT, pa, 1'b0, 1'b1);
        check("lock_after_ofs", oLOCK, 1);
        check("err_after_rst", oERR_CNT, 0);

`ifdef LVDS_RX_JEIDA_EN
        pj = '{r: 8'h81, g: 8'h42, b: 8'h24, de: 1'b0, hs: 1'b1, vs: 1'b0};
`else
        pj = '{r: 8'h60, g: 8'h90, b: 8'h09, de: 1'b0, hs: 1'b1, vs: 1'b0};
`endif
        send_raw(PAT, {7'b0001001, 7'b0010010, 7'b0101000, 7'b0100000}, 1'b1, pj);
        send_word(PAT, pa, 1'b0, 1'b1);
        check("q_depth_end", exp_q.size(), 1);
        idle(4);
        check("q_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
